// File: rtl/adat_deframer.sv
// ADAT frame deframer: aligns to the sync run, then unpacks user bits and 8x24-bit samples.
// Pulses appear one cycle after the accepting bit strobe; there is no backpressure, since outputs are plain strobes.
module adat_deframer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        data_i,
  input  logic        bit_en_i,
  input  logic        locked_i,
  output logic [23:0] sample_o,
  output logic [2:0]  channel_o,
  output logic        sample_valid_o,
  output logic [3:0]  user_o,
  output logic        user_valid_o,
  output logic        frame_sync_o,
  output logic        in_frame_o,
  output logic        error_o
);

  typedef enum logic [1:0] {HUNT, USER, CHAN} state_t;

  state_t      state, state_nx;
  logic [3:0]  zcnt, zcnt_nx;
  logic [2:0]  bcnt, bcnt_nx;
  logic [2:0]  nib, nib_nx;
  logic [2:0]  chan, chan_nx;
  logic [23:0] shreg, shreg_nx;
  logic [3:0]  ubits, ubits_nx;
  logic        post_frame, post_frame_nx;
  logic [23:0] sample_nx;
  logic [2:0]  channel_nx;
  logic [3:0]  user_nx;
  logic        in_frame_nx, sample_valid_nx, user_valid_nx, frame_sync_nx, error_nx;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= HUNT;
      zcnt           <= '0;
      bcnt           <= '0;
      nib            <= '0;
      chan           <= '0;
      shreg          <= '0;
      ubits          <= '0;
      post_frame     <= 1'b0;
      sample_o       <= '0;
      channel_o      <= '0;
      user_o         <= '0;
      in_frame_o     <= 1'b0;
      sample_valid_o <= 1'b0;
      user_valid_o   <= 1'b0;
      frame_sync_o   <= 1'b0;
      error_o        <= 1'b0;
    end else begin
      state          <= state_nx;
      zcnt           <= zcnt_nx;
      bcnt           <= bcnt_nx;
      nib            <= nib_nx;
      chan           <= chan_nx;
      shreg          <= shreg_nx;
      ubits          <= ubits_nx;
      post_frame     <= post_frame_nx;
      sample_o       <= sample_nx;
      channel_o      <= channel_nx;
      user_o         <= user_nx;
      in_frame_o     <= in_frame_nx;
      sample_valid_o <= sample_valid_nx;
      user_valid_o   <= user_valid_nx;
      frame_sync_o   <= frame_sync_nx;
      error_o        <= error_nx;
    end
  end

  always_comb begin
    state_nx        = state;
    zcnt_nx         = zcnt;
    bcnt_nx         = bcnt;
    nib_nx          = nib;
    chan_nx         = chan;
    shreg_nx        = shreg;
    ubits_nx        = ubits;
    post_frame_nx   = post_frame;
    sample_nx       = sample_o;
    channel_nx      = channel_o;
    user_nx         = user_o;
    in_frame_nx     = in_frame_o;
    sample_valid_nx = 1'b0;
    user_valid_nx   = 1'b0;
    frame_sync_nx   = 1'b0;
    error_nx        = 1'b0;

    if (!locked_i) begin
      // Lock loss silently abandons alignment; the decoder stream is meaningless until relock.
      state_nx      = HUNT;
      zcnt_nx       = '0;
      bcnt_nx       = '0;
      nib_nx        = '0;
      chan_nx       = '0;
      in_frame_nx   = 1'b0;
      post_frame_nx = 1'b0;
    end else if (bit_en_i) begin
      unique case (state)
        HUNT: begin
          if (!data_i) begin
            zcnt_nx = (zcnt == 4'hF) ? zcnt : zcnt + 4'd1;
          end else if (zcnt >= 4'd10) begin
            state_nx      = USER;
            frame_sync_nx = 1'b1;
            in_frame_nx   = 1'b1;
            post_frame_nx = 1'b0;
            bcnt_nx       = '0;
          end else begin
            zcnt_nx = '0;
            // A short gap right after a full frame means the sync slipped.
            if (post_frame) begin
              error_nx      = 1'b1;
              in_frame_nx   = 1'b0;
              post_frame_nx = 1'b0;
            end
          end
        end
        USER: begin
          if (bcnt < 3'd4) begin
            ubits_nx = {ubits[2:0], data_i};
            bcnt_nx  = bcnt + 3'd1;
          end else if (data_i) begin
            user_nx       = ubits;
            user_valid_nx = 1'b1;
            state_nx      = CHAN;
            bcnt_nx       = '0;
            nib_nx        = '0;
            chan_nx       = '0;
          end else begin
            error_nx    = 1'b1;
            in_frame_nx = 1'b0;
            state_nx    = HUNT;
            zcnt_nx     = 4'd1;
            bcnt_nx     = '0;
          end
        end
        CHAN: begin
          if (bcnt < 3'd4) begin
            shreg_nx = {shreg[22:0], data_i};
            bcnt_nx  = bcnt + 3'd1;
          end else if (data_i) begin
            bcnt_nx = '0;
            if (nib == 3'd5) begin
              sample_nx       = shreg;
              channel_nx      = chan;
              sample_valid_nx = 1'b1;
              nib_nx          = '0;
              if (chan == 3'd7) begin
                state_nx      = HUNT;
                zcnt_nx       = '0;
                chan_nx       = '0;
                post_frame_nx = 1'b1;
              end else begin
                chan_nx = chan + 3'd1;
              end
            end else begin
              nib_nx = nib + 3'd1;
            end
          end else begin
            // The bad separator zero is also the first zero of the next sync run.
            error_nx    = 1'b1;
            in_frame_nx = 1'b0;
            state_nx    = HUNT;
            zcnt_nx     = 4'd1;
            bcnt_nx     = '0;
            nib_nx      = '0;
            chan_nx     = '0;
          end
        end
        default: state_nx = HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_adat_deframer.sv
// Directed bench for adat_deframer: hand-built ADAT bit streams, monitor of output pulses, expected values fixed per test.
module tb_adat_deframer;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        data_i = 1'b0;
  logic        bit_en_i = 1'b0;
  logic        locked_i = 1'b1;
  logic [23:0] sample_o;
  logic [2:0]  channel_o;
  logic        sample_valid_o;
  logic [3:0]  user_o;
  logic        user_valid_o;
  logic        frame_sync_o;
  logic        in_frame_o;
  logic        error_o;

  adat_deframer dut (
    .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i), .bit_en_i(bit_en_i), .locked_i(locked_i),
    .sample_o(sample_o), .channel_o(channel_o), .sample_valid_o(sample_valid_o),
    .user_o(user_o), .user_valid_o(user_valid_o), .frame_sync_o(frame_sync_o),
    .in_frame_o(in_frame_o), .error_o(error_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: records every pulse at the falling edge.
  logic [23:0] mon_smp[$];
  logic [2:0]  mon_ch[$];
  int          n_sync = 0, n_uv = 0, n_err = 0;
  logic [3:0]  last_user = '0;
  logic        en_last = 1'b0;

  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (sample_valid_o || user_valid_o || frame_sync_o || error_o)
        check_eq("pulse_after_strobe", {31'd0, en_last}, 32'd1);
      if (sample_valid_o) begin
        mon_smp.push_back(sample_o);
        mon_ch.push_back(channel_o);
      end
      if (frame_sync_o) n_sync++;
      if (user_valid_o) begin
        n_uv++;
        last_user = user_o;
      end
      if (error_o) n_err++;
    end
    en_last = bit_en_i && locked_i;
  end

  bit bits[$];

  task automatic push_nib(input logic [3:0] n, input bit sep);
    for (int i = 3; i >= 0; i--) bits.push_back(n[i]);
    bits.push_back(sep);
  endtask

  task automatic push_sync();
    for (int i = 0; i < 10; i++) bits.push_back(1'b0);
    bits.push_back(1'b1);
  endtask

  task automatic push_chan(input logic [23:0] s);
    for (int k = 5; k >= 0; k--) push_nib(s[k*4 +: 4], 1'b1);
  endtask

  task automatic push_frame(input logic [3:0] u);
    push_sync();
    push_nib(u, 1'b1);
    for (int c = 0; c < 8; c++) push_chan(24'hA5A500 + 24'(c));
  endtask

  // Plays n bits from the queue; gap 0 gives back-to-back strobes, cadence>0 cycles gaps 3,4,5.
  task automatic play(input int n, input bit cadence);
    @(posedge clk_i); #1;
    for (int i = 0; i < n && bits.size() > 0; i++) begin
      data_i = bits.pop_front();
      bit_en_i = 1'b1;
      @(posedge clk_i); #1;
      bit_en_i = 1'b0;
      if (cadence) repeat (3 + (i % 3)) begin @(posedge clk_i); #1; end
    end
    repeat (2) @(posedge clk_i);
    #1;
  endtask

  task automatic clear_mon();
    mon_smp.delete();
    mon_ch.delete();
    n_sync = 0;
    n_uv = 0;
    n_err = 0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    clear_mon();
  endtask

  task automatic check_samples(input string tag, input int first, input int count);
    for (int i = 0; i < count; i++) begin
      check_eq({tag, "_ch"}, {29'd0, mon_ch[first + i]}, 32'(i % 8));
      check_eq({tag, "_smp"}, {8'd0, mon_smp[first + i]}, 32'h00A5A500 + 32'(i % 8));
    end
  endtask

  task automatic run_two_frames(input string tag, input bit cadence);
    do_reset();
    push_frame(4'b1010);
    push_frame(4'b1010);
    play(bits.size(), cadence);
    check_eq({tag, "_syncs"}, n_sync, 2);
    check_eq({tag, "_uvalid"}, n_uv, 2);
    check_eq({tag, "_user"}, {28'd0, last_user}, 32'hA);
    check_eq({tag, "_nsamp"}, mon_smp.size(), 16);
    if (mon_smp.size() == 16) check_samples(tag, 0, 16);
    check_eq({tag, "_err"}, n_err, 0);
    check_eq({tag, "_inframe"}, {31'd0, in_frame_o}, 1);
  endtask

  initial begin
    // Reset state
    #2;
    check_eq("rst_sample", {8'd0, sample_o}, 0);
    check_eq("rst_channel", {29'd0, channel_o}, 0);
    check_eq("rst_user", {28'd0, user_o}, 0);
    check_eq("rst_pulses", {28'd0, sample_valid_o, user_valid_o, frame_sync_o, error_o}, 0);
    check_eq("rst_inframe", {31'd0, in_frame_o}, 0);

    // Two clean frames, back-to-back strobes
    run_two_frames("clean", 1'b0);

    // Nine zeros is not a sync; the following proper sync locks
    do_reset();
    for (int i = 0; i < 9; i++) bits.push_back(1'b0);
    bits.push_back(1'b1);
    play(bits.size(), 1'b0);
    check_eq("short_sync_nosync", n_sync, 0);
    check_eq("short_sync_inframe", {31'd0, in_frame_o}, 0);
    push_frame(4'b1010);
    play(bits.size(), 1'b0);
    check_eq("short_sync_relock", n_sync, 1);
    check_eq("short_sync_nsamp", mon_smp.size(), 8);
    check_eq("short_sync_err", n_err, 0);

    // Bad separator after channel 3 nibble 2
    do_reset();
    push_sync();
    push_nib(4'b1010, 1'b1);
    for (int c = 0; c < 3; c++) push_chan(24'hA5A500 + 24'(c));
    push_nib(4'hA, 1'b1);
    push_nib(4'h5, 1'b1);
    push_nib(4'hA, 1'b0);
    play(bits.size(), 1'b0);
    check_eq("sep_err_count", n_err, 1);
    check_eq("sep_err_inframe", {31'd0, in_frame_o}, 0);
    check_eq("sep_err_nsamp", mon_smp.size(), 3);
    push_frame(4'b1010);
    play(bits.size(), 1'b0);
    check_eq("sep_err_relock", n_sync, 2);
    check_eq("sep_err_nsamp2", mon_smp.size(), 11);
    if (mon_smp.size() == 11) check_samples("sep_err_relock", 3, 8);
    check_eq("sep_err_count2", n_err, 1);

    // Lock dropped for 5 cycles in channel 5
    do_reset();
    push_frame(4'b1010);
    play(176, 1'b0);
    locked_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #1 locked_i = 1'b1;
    check_eq("lock_inframe", {31'd0, in_frame_o}, 0);
    play(bits.size(), 1'b0);
    check_eq("lock_nsamp", mon_smp.size(), 5);
    check_eq("lock_err", n_err, 0);
    push_frame(4'b1010);
    play(bits.size(), 1'b0);
    check_eq("lock_relock", n_sync, 2);
    check_eq("lock_nsamp2", mon_smp.size(), 13);
    check_eq("lock_err2", n_err, 0);

    // Decoder cadence: 3-5 idle cycles between strobes
    run_two_frames("cadence", 1'b1);

    // Asynchronous reset in channel 2
    do_reset();
    push_frame(4'b1010);
    play(83, 1'b0);
    check_eq("arst_pre_sample", {8'd0, sample_o}, 32'h00A5A501);
    check_eq("arst_pre_inframe", {31'd0, in_frame_o}, 1);
    #3 rst_i = 1'b1;
    #1;
    check_eq("arst_sample", {8'd0, sample_o}, 0);
    check_eq("arst_channel", {29'd0, channel_o}, 0);
    check_eq("arst_user", {28'd0, user_o}, 0);
    check_eq("arst_inframe", {31'd0, in_frame_o}, 0);
    check_eq("arst_pulses", {28'd0, sample_valid_o, user_valid_o, frame_sync_o, error_o}, 0);
    #12 rst_i = 1'b0;
    clear_mon();
    bits.delete();
    push_frame(4'b1010);
    play(bits.size(), 1'b0);
    check_eq("arst_syncs", n_sync, 1);
    check_eq("arst_nsamp", mon_smp.size(), 8);
    if (mon_smp.size() == 8) check_samples("arst_after", 0, 8);
    check_eq("arst_err", n_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
